count_sequence_checker: RTL

Downstream monitor for the N-bit up/down counter. Samples the counter value and its direction control each cycle and checks that every step is exactly ±1 modulo 2^WIDTH in the commanded direction. Reports mismatches and wrap-arounds as pulses, sticky flags and counters. Lock state comes from a small state machine with a resynchronisation policy.

---
 rtl/count_sequence_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/count_sequence_checker.sv
// count_sequence_checker: monitors an up/down counter and checks that every
// sample is exactly one step (mod 2^WIDTH) from the previous one in the
// direction captured with that previous sample. Mismatches and wraps are
// reported as one-cycle pulses, a sticky error flag and counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// UNLOCKED | no valid previous sample; next en sample is captured only
// LOCKED   | previous sample held in last_q; each en sample is checked
module count_sequence_checker #(
  parameter int WIDTH      = 3,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8,
  parameter int MISS_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  direction,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  clear,
  output logic                  locked,
  output logic [WIDTH-1:0]      expected,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count
);

  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [WIDTH-1:0]      ONE       = 1;
  localparam logic [MISS_W-1:0]     MISS_ONE  = 1;
  localparam logic [MISS_W-1:0]     MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic [ERR_CNT_W-1:0]  ERR_ONE   = 1;
  localparam logic [WRAP_CNT_W-1:0] WRAP_ONE  = 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        last_q, last_d;
  logic                    last_dir_q, last_dir_d;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic [WIDTH-1:0]        expected_q, expected_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    wrap_pulse_q, wrap_pulse_d;
  logic                    err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0]    err_count_q, err_count_d;
  logic [WRAP_CNT_W-1:0]   wrap_count_q, wrap_count_d;

  logic [WIDTH-1:0]        pred;
  logic                    upd;
  logic                    err_ev;
  logic                    wrap_ev;
  logic [ERR_CNT_W-1:0]    err_base;
  logic [WRAP_CNT_W-1:0]   wrap_base;

  // State register and all registered outputs; rst has highest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      last_q       <= '0;
      last_dir_q   <= 1'b0;
      miss_q       <= '0;
      expected_q   <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      last_dir_q   <= last_dir_d;
      miss_q       <= miss_d;
      expected_q   <= expected_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // Next-state, sample check, resync and event counters.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    last_dir_d = last_dir_q;
    miss_d     = miss_q;
    expected_d = expected_q;
    upd        = 1'b0;
    err_ev     = 1'b0;
    wrap_ev    = 1'b0;
    pred       = last_dir_q ? (last_q + ONE) : (last_q - ONE);

    if (!en) begin
      // A gap breaks the sample chain; expected holds.
      state_d = UNLOCKED;
      miss_d  = '0;
    end else if (state_q == UNLOCKED) begin
      upd     = 1'b1;
      state_d = LOCKED;
      miss_d  = '0;
    end else if (count_in == pred) begin
      upd     = 1'b1;
      miss_d  = '0;
      wrap_ev = last_dir_q ? (&last_q) : (~|last_q);
    end else begin
      // Resync on the observed value even though it was wrong.
      upd    = 1'b1;
      err_ev = 1'b1;
      if (miss_q == MISS_LAST) begin
        state_d = UNLOCKED;
        miss_d  = '0;
      end else begin
        miss_d = miss_q + MISS_ONE;
      end
    end

    if (upd) begin
      last_d     = count_in;
      last_dir_d = direction;
      expected_d = direction ? (count_in + ONE) : (count_in - ONE);
    end

    // An event in the same cycle as clear wins over the clear.
    err_pulse_d  = err_ev;
    wrap_pulse_d = wrap_ev;
    err_sticky_d = err_ev | (err_sticky_q & ~clear);
    err_base     = clear ? '0 : err_count_q;
    err_count_d  = (err_ev && !(&err_base)) ? (err_base + ERR_ONE) : err_base;
    wrap_base    = clear ? '0 : wrap_count_q;
    wrap_count_d = wrap_ev ? (wrap_base + WRAP_ONE) : wrap_base;
  end

  assign locked     = (state_q == LOCKED);
  assign expected   = expected_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule
